// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned STARVE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of consecutive arbitrations the fetch path has lost.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered, handshaked arbiter granting the single memory port to fetch or load/store.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              idle;
    logic              if_win;
    logic              d_win;
    logic              at_limit;
    logic              defer_inc;
    logic              defer_clr;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    // Grants are gated by rst so nothing is strobed while reset is held.
    always_comb begin
        idle   = rst && (state_q == IDLE);
        if_win = idle && if_req && (!d_req || at_limit);
        d_win  = idle && d_req && !if_win;
    end

    always_comb begin
        state_d    = state_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        defer_inc  = 1'b0;
        defer_clr  = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                defer_inc = idle && if_req && d_win;
                defer_clr = idle && (if_win || !if_req);
                if (if_win) begin
                    if_gnt   = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = if_addr;
                    state_d  = IF_WAIT;
                end else if (d_win) begin
                    d_gnt    = 1'b1;
                    mem_addr = d_addr;
                    if (d_we) begin
                        mem_write = 1'b1;
                        mem_wdata = d_wdata;
                    end else begin
                        mem_read = 1'b1;
                        state_d  = D_WAIT;
                    end
                end
            end
            IF_WAIT: begin
                if_rdata_d = mem_rdata;
                state_d    = IDLE;
            end
            D_WAIT: begin
                d_rdata_d = mem_rdata;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            if_rvalid_q <= (state_q == IF_WAIT);
            d_rvalid_q  <= (state_q == D_WAIT);
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst),
        .inc_i      (defer_inc),
        .clr_i      (defer_clr),
        .at_limit_o (at_limit)
    );

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and arbitrates the single-port unified instruction/data memory between two requesters: the fetch path and the load/store path.
- Replaces the combinational fetch/data address mux with a registered, handshaked controller.
- Enables a multi-cycle core in which the memory is granted to one requester per access.
- Sits between the core (fetch unit, load/store unit) and the Mem block.

Parameters:
- ADDR_W, 7, memory byte-address width.
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch is forced to win; legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  registered one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  instruction register; holds its value until the next fetch response.
- d_req  in  1  data request; held with d_* stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  registered one-cycle pulse on load response.
- d_rdata  out  DATA_W  load data register; holds its value until the next load response.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_read.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE and defer_cnt to 0.
  - if_rdata, d_rdata, if_rvalid and d_rvalid are cleared to 0.
  - mem_read, mem_write, if_gnt and d_gnt are 0; mem_addr and mem_wdata are 0.
  - Any in-flight read is dropped and no rvalid is produced for it after reset release.
- States: IDLE, IF_WAIT, D_WAIT.
- Arbitration happens only in IDLE; grant signals are combinational from state and the request inputs.
  - Only one request asserted: that request wins.
  - Both asserted: data wins unless defer_cnt == STARVE_LIMIT, in which case fetch wins.
- Grant cycle:
  - Memory strobes and address are driven combinationally from the winner in the same cycle.
  - Fetch granted: mem_read=1, mem_addr=if_addr, next state IF_WAIT.
  - Load granted: mem_read=1, mem_addr=d_addr, next state D_WAIT.
  - Store granted: mem_write=1, mem_addr=d_addr, mem_wdata=d_wdata. Commits at the grant-cycle edge; next state stays IDLE; no d_rvalid.
- IF_WAIT / D_WAIT:
  - No grants and no memory strobes.
  - mem_rdata is captured into if_rdata / d_rdata at the closing edge; the matching rvalid is 1 in the following cycle; next state IDLE.
- Latency and throughput:
  - Grant in cycle N; rvalid and rdata in cycle N+2.
  - Reads issue at most one per 2 cycles; stores may issue back-to-back.
- defer_cnt (4-bit), updated in IDLE only:
  - Increments (saturating at STARVE_LIMIT) when if_req=1 and data wins.
  - Clears when fetch is granted or when if_req=0.
  - Holds in the wait states.
- A requester dropping req before its gnt is legal: the request is withdrawn with no side effect.
- rvalid pulses are exactly one cycle and rdata holds afterwards.
- A requester may raise a new req in the same cycle its rvalid is high; it is eligible for arbitration that cycle, since the state is IDLE.
- Outside a grant cycle, mem_addr and mem_wdata are 0.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, IF_WAIT, D_WAIT) with 2-bit encoding.
  - Default ADDR_W and DATA_W constants.
  - STARVE_W = 4.
- One sub-module: arb_starve_counter. Saturating counter with inc/clr inputs and an at_limit output, parameterised by STARVE_LIMIT.

Test Plan:
- Reset: assert rst=0 mid-fetch (in IF_WAIT), release -> all outputs 0, no if_rvalid afterwards, busy=0.
- Lone fetch: if_req=1, if_addr=0x10, mem word 0x00500093 -> if_gnt and mem_read in cycle N, if_rvalid=1 with if_rdata=0x00500093 in N+2; if_rdata held after the pulse.
- Back-to-back stores: d_req=1, d_we=1, addr 0x20/0x24, wdata 0xDEADBEEF/0x12345678 on consecutive cycles -> d_gnt in both cycles, a later load of 0x24 returns 0x12345678, d_rvalid only for the load.
- Contention: if_req and d_req (load) held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,IF,D... with one grant per 2 cycles.
- Withdrawn request: if_req high one cycle while the data access is in D_WAIT, then low -> no if_gnt, no if_rvalid, defer_cnt=0.
